// File: rtl/sample_buffer_reader.sv
// Sample history buffer that snapshots its live contents on start and streams them out, oldest first.
// Optional trailing XOR checksum word when SAMPLE_READER_CHECKSUM_EN is defined.
module sample_buffer_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fill_count
);

`ifdef SAMPLE_READER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
  logic [WIDTH-1:0] csum;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state;
  logic [WIDTH-1:0] hist   [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [CNT_W-1:0] rd_idx;
  logic [CNT_W-1:0] first_idx;

  // Newest sample always sits at DEPTH-1, so the valid entries are the top fill_count slots.
  assign first_idx = DEPTH_C - fill_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fill_count <= '0;
      rd_idx     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
      csum       <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        hist[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      if (wr_en) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          hist[i] <= hist[i+1];
        end
        hist[DEPTH-1] <= wr_data;
        if (fill_count != DEPTH_C) begin
          fill_count <= fill_count + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start && fill_count != '0) begin
            // First word comes straight from live history; shadow is only loaded this same edge.
            for (int i = 0; i < DEPTH; i++) begin
              shadow[i] <= hist[i];
            end
            state     <= STREAM;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= hist[first_idx];
            rd_idx    <= first_idx + 1'b1;
`ifdef SAMPLE_READER_CHECKSUM_EN
            csum      <= hist[first_idx];
            out_last  <= 1'b0;
`else
            out_last  <= (first_idx == DEPTH_C - 1'b1);
`endif
          end
        end

        STREAM: begin
          if (out_ready) begin
            if (rd_idx == DEPTH_C) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
              state    <= CSUM;
              out_data <= csum;
              out_last <= 1'b1;
`else
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
`endif
            end else begin
              out_data <= shadow[rd_idx];
              rd_idx   <= rd_idx + 1'b1;
`ifdef SAMPLE_READER_CHECKSUM_EN
              csum     <= csum ^ shadow[rd_idx];
`else
              out_last <= (rd_idx == DEPTH_C - 1'b1);
`endif
            end
          end
        end

`ifdef SAMPLE_READER_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Randomised self-checking bench for sample_buffer_reader against a queue-based model of the live history.
module tb_sample_buffer_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] fill_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] frame_q[$];
  logic [WIDTH-1:0] last_word;

  sample_buffer_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [WIDTH-1:0] d);
    model_q.push_back(d);
    if (model_q.size() > DEPTH) void'(model_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    model_q.delete();
    step();
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
    model_write(d);
  endtask

  task automatic begin_frame();
    frame_q = model_q;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready
  task automatic run_frame(input int mode, input bit wr_during, input bit chain, output int cyc);
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;
    logic rdy;
    bit stalled;
    int got;
    int n;
    expq = frame_q;
    x = '0;
    foreach (expq[i]) x = x ^ expq[i];
`ifdef SAMPLE_READER_CHECKSUM_EN
    expq.push_back(x);
`endif
    n = expq.size();
    got = 0; cyc = 0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (got < n && cyc < 200) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL frame_valid word %0d: out_valid=%b busy=%b required 1/1", got, out_valid, busy);
      end
      if (stalled) begin
        checks++;
        if (out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: data=%h last=%b required %h/%b", out_data, out_last, prev_data, prev_last);
        end
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (wr_during && $urandom_range(0, 2) == 0) begin
        wr_en = 1'b1;
        wr_data = WIDTH'($urandom);
        model_write(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      if (out_valid && rdy) begin
        checks++;
        if (out_data !== expq[got] || out_last !== (got == n - 1)) begin
          errors++;
          $display("FAIL frame_word %0d: data=%h last=%b required %h/%b", got, out_data, out_last, expq[got], (got == n - 1));
        end
        last_word = out_data;
        got++;
      end
      stalled = out_valid && !rdy;
      prev_data = out_data;
      prev_last = out_last;
      step();
      cyc++;
    end
    wr_en = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL frame_timeout: got %0d words required %0d", got, n);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: done=%b busy=%b out_valid=%b required 1/0/0", done, busy, out_valid);
    end
    if (chain) begin
      begin_frame();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL chain_start: done=%b out_valid=%b busy=%b required 0/1/1", done, out_valid, busy);
      end
    end else begin
      step();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: done=%b out_valid=%b required 0/0", done, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== '0 || fill_count !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b l=%b b=%b d=%b data=%h fill=%0d required all zero",
               out_valid, out_last, busy, done, out_data, fill_count);
    end
  endtask

  task automatic test_basic();
    int cyc;
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    begin_frame();
    run_frame(0, 1'b0, 1'b0, cyc);
    checks++;
`ifdef SAMPLE_READER_CHECKSUM_EN
    if (cyc != 4) begin
      errors++;
      $display("FAIL basic_cycles: %0d required 4", cyc);
    end
`else
    if (cyc != 3) begin
      errors++;
      $display("FAIL basic_cycles: %0d required 3", cyc);
    end
`endif
    checks++;
    if (fill_count !== 4'd3) begin
      errors++;
      $display("FAIL basic_fill: %0d required 3", fill_count);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    do_reset();
    for (int i = 1; i <= 12; i++) push(WIDTH'(i));
    checks++;
    if (fill_count !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL overflow_fill: %0d required %0d", fill_count, DEPTH);
    end
    begin_frame();
    run_frame(0, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_stall();
    int cyc;
    do_reset();
    push(8'hA0); push(8'hB0);
    begin_frame();
    run_frame(1, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_empty_and_same_cycle();
    int cyc;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL empty_start: v=%b b=%b d=%b required 0/0/0", out_valid, busy, done);
      end
      step();
    end
    push(8'h44);
    frame_q = model_q;
    start = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    step();
    start = 1'b0; wr_en = 1'b0;
    model_write(8'h55);
    run_frame(0, 1'b0, 1'b0, cyc);
    checks++;
    if (fill_count !== 4'd2) begin
      errors++;
      $display("FAIL same_cycle_fill: %0d required 2", fill_count);
    end
  endtask

  task automatic test_checksum();
    int cyc;
    do_reset();
    push(8'h0F); push(8'hF0); push(8'h33);
    begin_frame();
    run_frame(0, 1'b0, 1'b0, cyc);
    checks++;
`ifdef SAMPLE_READER_CHECKSUM_EN
    if (last_word !== 8'hCC) begin
      errors++;
      $display("FAIL checksum_last: %h required cc", last_word);
    end
`else
    if (last_word !== 8'h33) begin
      errors++;
      $display("FAIL checksum_last: %h required 33", last_word);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 5; i++) push(WIDTH'(8'h60 + i));
    begin_frame();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== '0 || fill_count !== '0) begin
      errors++;
      $display("FAIL reset_mid: v=%b l=%b b=%b d=%b data=%h fill=%0d required all zero",
               out_valid, out_last, busy, done, out_data, fill_count);
    end
    step();
    reset = 1'b0;
    model_q.delete();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_start: v=%b b=%b d=%b required 0/0/0", out_valid, busy, done);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    push(8'h5A); push(8'hA5);
    begin_frame();
    run_frame(0, 1'b0, 1'b1, cyc);
    run_frame(2, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_random();
    int cyc;
    int n;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step();
        push(WIDTH'($urandom));
      end
      begin_frame();
      run_frame(2, 1'b1, 1'b0, cyc);
      checks++;
      if (fill_count !== CNT_W'(model_q.size())) begin
        errors++;
        $display("FAIL random_fill it %0d: %0d required %0d", it, fill_count, model_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_empty_and_same_cycle();
    test_checksum();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
